uart_msg_tx: RTL and testbench

UART_MSG_TX -- requirements
Module: uart_msg_tx

---
 rtl/uart_msg_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_msg_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_tx.sv
// Streams a buffered message out of a UART, one frame per byte, fetching each byte from external memory.
// Optional build macro UART_MSG_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_msg_tx #(
  parameter int WIDTH        = 8,
  parameter int LEN          = 256,
  parameter int CLKS_PER_BIT = 234,
  localparam int AW          = $clog2(LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_valid,
  input  logic [AW-1:0]    msg_len,
  output logic [AW-1:0]    addr,
  output logic             rd_en,
  input  logic [WIDTH-1:0] dout,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_MSG_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rd_en_q, rd_en_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_MSG_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    timer_d = '0;
    bit_d   = bit_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef UART_MSG_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          cnt_d   = msg_len;
          idx_d   = '0;
          state_d = (msg_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sh_d    = dout;
`ifdef UART_MSG_TX_PARITY_EN
        par_d   = ^dout;
`endif
        state_d = S_START;
      end
      S_START: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          if (bit_q == BW'(WIDTH - 1)) begin
`ifdef UART_MSG_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
            sh_d  = sh_q >> 1;
          end
        end
      end
`ifdef UART_MSG_TX_PARITY_EN
      S_PARITY: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          idx_d   = idx_q + AW'(1);
          state_d = (idx_q + AW'(1) == cnt_q) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are registered from the next state, so tx changes exactly at state boundaries without glitches.
  always_comb begin
    rd_en_d = (state_d == S_FETCH);
    addr_d  = (state_d == S_FETCH) ? idx_d : addr_q;
    busy_d  = (state_q != S_IDLE) || msg_valid;
    done_d  = (state_q == S_DONE);
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
`ifdef UART_MSG_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_MSG_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_MSG_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign addr  = addr_q;
  assign rd_en = rd_en_q;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx: decodes the serial line from a per-cycle log and compares
// against the expected byte list, frame timing, read strobes, busy and done.
module tb_uart_msg_tx;

  localparam int WIDTH = 8;
  localparam int LEN   = 256;
  localparam int CPB   = 4;
  localparam int AW    = 9;
`ifdef UART_MSG_TX_PARITY_EN
  localparam int NB    = WIDTH + 3;
`else
  localparam int NB    = WIDTH + 2;
`endif
  localparam int FRAME = NB * CPB;
  localparam int MAXC  = 30000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             msg_valid = 1'b0;
  logic [AW-1:0]    msg_len = '0;
  logic [AW-1:0]    addr;
  logic             rd_en;
  logic [WIDTH-1:0] dout = '0;
  logic             tx, busy, done;

  logic [7:0]    mem [LEN];
  logic          tx_log   [MAXC];
  logic          busy_log [MAXC];
  logic          done_log [MAXC];
  logic          rd_log   [MAXC];
  logic [AW-1:0] addr_log [MAXC];
  logic [7:0]    exp_q[$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  uart_msg_tx #(.WIDTH(WIDTH), .LEN(LEN), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_len(msg_len),
    .addr(addr), .rd_en(rd_en), .dout(dout), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Buffer model (data valid one cycle after the strobe) plus per-cycle logging of DUT outputs.
  always @(negedge clk) begin
    if (rd_pend) dout = (int'(rd_addr) < LEN) ? mem[rd_addr[7:0]] : 8'h00;
    else         dout = WIDTH'($urandom);
    rd_pend = rd_en;
    rd_addr = addr;
    if (cyc < MAXC) begin
      tx_log[cyc]   = tx;
      busy_log[cyc] = busy;
      done_log[cyc] = done;
      rd_log[cyc]   = rd_en;
      addr_log[cyc] = addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < LEN; i++) mem[i] = (i < exp_q.size()) ? exp_q[i] : 8'($urandom);
  endtask

  task automatic analyze(input int c0, input int b, input string tag);
    int i, nf, bad, gap_bad, first, prev, reads, rd_bad, done_n, done_at, exp_done, busy_bad;
    logic [NB-1:0] bits;
    i = c0 + 1; nf = 0; bad = 0; gap_bad = 0; first = -1; prev = -1;
    while (i <= b) begin
      if (tx_log[i] === 1'b1) i++;
      else begin
        if (i + FRAME - 1 > b) begin bad++; break; end
        for (int k = 0; k < NB; k++) begin
          bits[k] = tx_log[i + k*CPB];
          for (int j = 1; j < CPB; j++) if (tx_log[i + k*CPB + j] !== bits[k]) bad++;
        end
        if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) bad++;
        if (nf < exp_q.size()) begin
          check({tag, " byte"}, 32'(bits[8:1]), 32'(exp_q[nf]));
`ifdef UART_MSG_TX_PARITY_EN
          check({tag, " parity"}, 32'(bits[9]), 32'(^exp_q[nf]));
`endif
        end
        if (nf == 0) first = i;
        else if (i - prev != FRAME + 2) gap_bad++;
        prev = i; nf++; i += FRAME;
      end
    end
    check({tag, " frames"}, nf, exp_q.size());
    check({tag, " frame_shape_errs"}, bad, 0);
    if (exp_q.size() > 0) begin
      check({tag, " first_start_cycle"}, first, c0 + 3);
      check({tag, " gap_errs"}, gap_bad, 0);
    end
    reads = 0; rd_bad = 0; done_n = 0; done_at = -1;
    for (int c = c0 + 1; c <= b; c++) begin
      if (rd_log[c] === 1'b1) begin
        if (int'(addr_log[c]) != reads) rd_bad++;
        reads++;
      end
      if (done_log[c] === 1'b1) begin done_n++; if (done_at < 0) done_at = c; end
    end
    check({tag, " reads"}, reads, exp_q.size());
    check({tag, " read_addr_errs"}, rd_bad, 0);
    check({tag, " done_pulses"}, done_n, 1);
    exp_done = (exp_q.size() > 0) ? prev + FRAME + 1 : c0 + 2;
    check({tag, " done_cycle"}, done_at, exp_done);
    busy_bad = 0;
    for (int c = c0 + 1; c <= exp_done && c <= b; c++) if (busy_log[c] !== 1'b1) busy_bad++;
    check({tag, " busy_low_cycles"}, busy_bad, 0);
    if (exp_done + 1 <= b) check({tag, " busy_after_done"}, 32'(busy_log[exp_done + 1]), 0);
  endtask

  // Sends the message held in exp_q; extra_at>0 pulses a second msg_valid (len 5) that many cycles in.
  task automatic send(input int len, input int extra_at, input string tag);
    int c0, budget;
    bit seen;
    load_mem();
    @(negedge clk);
    msg_valid = 1'b1; msg_len = AW'(len); c0 = cyc;
    @(negedge clk);
    msg_valid = 1'b0; msg_len = AW'($urandom);
    budget = (len + 1) * (FRAME + 2) + 20;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
      msg_valid = (extra_at > 0 && k + 1 == extra_at);
      if (msg_valid) msg_len = AW'(5);
    end
    msg_valid = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 1);
    repeat (2) @(negedge clk);
    analyze(c0, cyc - 1, tag);
  endtask

  initial begin
    int c0, n, lows, dn;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 1);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset rd_en", 32'(rd_en), 0);
    check("reset addr", 32'(addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    exp_q = '{8'h48, 8'h69};
    send(2, 0, "hi");

    exp_q = '{};
    send(0, 0, "len0");

    exp_q = '{8'h07, 8'h03};
    send(2, 0, "par");

    exp_q = '{8'($urandom), 8'($urandom)};
    send(2, 30, "ignore2nd");

    // Abort during data bit 3 of byte 0, then verify nothing else comes out.
    exp_q = '{8'hA5, 8'h3C};
    load_mem();
    @(negedge clk);
    msg_valid = 1'b1; msg_len = AW'(2); c0 = cyc;
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("abort bit3_on_line", 32'(tx), 32'(exp_q[0][3]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort tx", 32'(tx), 1);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    repeat (12) @(negedge clk);
    lows = 0; dn = 0;
    for (int c = c0 + 21; c < cyc; c++) begin
      if (tx_log[c] !== 1'b1) lows++;
      if (done_log[c] !== 1'b0) dn++;
    end
    check("abort tx_low_after", lows, 0);
    check("abort done_after", dn, 0);

    // msg_valid coincident with reset must be dropped.
    @(negedge clk);
    rst = 1'b1; msg_valid = 1'b1; msg_len = AW'(3); c0 = cyc;
    @(negedge clk);
    rst = 1'b0; msg_valid = 1'b0;
    repeat (8) @(negedge clk);
    lows = 0;
    for (int c = c0 + 1; c < cyc; c++)
      if (busy_log[c] !== 1'b0 || rd_log[c] !== 1'b0 || tx_log[c] !== 1'b1) lows++;
    check("rstvalid activity", lows, 0);

    exp_q = '{8'h11, 8'hEE, 8'h80};
    send(3, 0, "after_abort");

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      exp_q = '{};
      for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
      send(n, 0, $sformatf("rand%0d", r));
    end

    exp_q = '{};
    for (int i = 0; i < LEN; i++) exp_q.push_back(8'(i));
    send(LEN, 0, "full256");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
